// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch stage.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  // One buffered fetch result: PC in the upper half, instruction in the lower.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular response buffer with synchronous clear and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage write; contents need no reset since occupancy lives in the pointers.
  always_ff @(posedge clk)
    if (push && !clear) mem_q[wr_q] <= wdata;

  // Pointer and count update; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= nxt(wr_q);
      if (pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC ownership, imem request issue, in-order response
// buffering, decode output register, stall and redirect handling.
module fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        dec_stall,
  input  logic        exec_redirect,
  input  logic [31:0] exec_redirect_pc,
  output logic [31:0] ftch_dec_instr,
  output logic [31:0] ftch_dec_pc,
  output logic        ftch_dec_valid
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   osd_q, osd_d;     // requests handshaken, response not yet seen
  logic [CW-1:0]   drop_q, drop_d;   // in-flight responses still to be discarded
  logic            en_q;             // keeps the request channel quiet while in reset

  logic [XLEN-1:0] instr_q, instr_d, dpc_q, dpc_d;
  logic            dvld_q, dvld_d;

  logic            req_fire, rsp_keep, push, pop;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     inflight;
  logic            fifo_empty, fifo_full;
  logic [XLEN-1:0] rsp_pc;
  fetch_entry_t    fifo_head, rsp_entry;

  // Issue while buffer + in-flight leaves room for every answer; this is what
  // makes FIFO overflow impossible.
  assign inflight       = (CW+1)'(fifo_cnt) + (CW+1)'(osd_q);
  assign imem_req_valid = en_q && (state_q == RUN) && (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A kept response always belongs to the oldest of the osd_q consecutive
  // requests that ended at pc_q-4, so its PC is recovered without a tag queue.
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !exec_redirect;
  assign rsp_pc   = pc_q - XLEN'({osd_q, 2'b00});

  always_comb begin
    rsp_entry.pc    = rsp_pc;
    rsp_entry.instr = imem_rsp_data;
  end

  // Next-state for PC, counters and FSM; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    osd_d   = osd_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (req_fire) pc_d = pc_q + 32'd4;
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if ((state_q == FLUSH) && (drop_q == '0)) state_d = RUN;
    if (exec_redirect) begin
      pc_d = exec_redirect_pc & ~32'h3;
      // Everything still in flight after this edge is stale: that already
      // includes a same-cycle handshake and excludes a same-cycle response,
      // which the flush swallows here.
      drop_d  = osd_d;
      state_d = (osd_d != '0) ? FLUSH : RUN;
    end
  end

  // PC, counters and FSM state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      osd_q   <= '0;
      drop_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      osd_q   <= osd_d;
      drop_q  <= drop_d;
      en_q    <= 1'b1;
    end

  // Decode output selection: FIFO head first, then bypass of a live response,
  // else bubble. Stall holds; redirect forces a bubble and clears the buffer.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    dvld_d  = dvld_q;
    if (exec_redirect) begin
      instr_d = INSTR_NOP;
      dpc_d   = '0;
      dvld_d  = 1'b0;
    end else if (!dec_stall) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        push    = rsp_keep;
        instr_d = fifo_head.instr;
        dpc_d   = fifo_head.pc;
        dvld_d  = 1'b1;
      end else if (rsp_keep) begin
        instr_d = imem_rsp_data;
        dpc_d   = rsp_pc;
        dvld_d  = 1'b1;
      end else begin
        instr_d = INSTR_NOP;
        dpc_d   = '0;
        dvld_d  = 1'b0;
      end
    end else begin
      push = rsp_keep;
    end
  end

  // Decode-facing output register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_q <= INSTR_NOP;
      dpc_q   <= '0;
      dvld_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      dvld_q  <= dvld_d;
    end

  assign ftch_dec_instr = instr_q;
  assign ftch_dec_pc    = dpc_q;
  assign ftch_dec_valid = dvld_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (exec_redirect),
    .wdata (rsp_entry),
    .rdata (fifo_head),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: a latency-L memory model, an in-order expected
// instruction queue filled at request handshake and drained at decode.
module tb_fetch;
  import cpu_pkg::*;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_stall, exec_redirect;
  logic [31:0] exec_redirect_pc;
  logic [31:0] ftch_dec_instr, ftch_dec_pc;
  logic        ftch_dec_valid;

  int          n_chk = 0, n_err = 0;
  int          cyc, lat, first_vld, hs_cnt;
  bit          hs_seen, found;
  logic [31:0] nxt_pc, first_hs_addr, snap_i, snap_p, snap_a;
  logic        snap_v;
  ent_t        exp_q[$];
  pend_t       pend[$];

  always #5 clk = ~clk;

  fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .dec_stall        (dec_stall),
    .exec_redirect    (exec_redirect),
    .exec_redirect_pc (exec_redirect_pc),
    .ftch_dec_instr   (ftch_dec_instr),
    .ftch_dec_pc      (ftch_dec_pc),
    .ftch_dec_valid   (ftch_dec_valid)
  );

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: drive memory response, sample at negedge+1, score, advance.
  task automatic tick();
    logic hs;
    ent_t e;
    int   lim;
    if (pend.size() > 0 && pend[0].due == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mword(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    hs = imem_req_valid && imem_req_ready;
    if (hs) begin
      chk("req_addr", imem_req_addr, nxt_pc);
      nxt_pc = nxt_pc + 32'd4;
      hs_cnt++;
      if (!hs_seen) begin hs_seen = 1'b1; first_hs_addr = imem_req_addr; end
    end
    if (ftch_dec_valid && first_vld < 0) first_vld = cyc;
    if (ftch_dec_valid && !dec_stall) begin
      chk("dec_have_exp", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dec_pc", ftch_dec_pc, e.pc);
        chk("dec_instr", ftch_dec_instr, e.instr);
      end
    end
    if (!ftch_dec_valid) chk("bubble_nop", ftch_dec_instr, INSTR_NOP);
    lim = 2 + ((ftch_dec_valid && dec_stall) ? 1 : 0);
    chk("occupancy", 32'(exp_q.size() <= lim), 32'd1);
    if (exec_redirect) begin
      exp_q.delete();
      nxt_pc = exec_redirect_pc & ~32'h3;
    end else if (hs) begin
      exp_q.push_back('{imem_req_addr, mword(imem_req_addr)});
    end
    if (hs) pend.push_back('{imem_req_addr, cyc + 1 + lat});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_first(input string tag, input logic [31:0] pc);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ftch_dec_valid) begin
        got = 1'b1;
        chk(tag, ftch_dec_pc, pc);
      end
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_dec_valid"}, 32'(ftch_dec_valid), 32'd0);
    chk({tag, "_dec_instr"}, ftch_dec_instr, INSTR_NOP);
    chk({tag, "_dec_pc"}, ftch_dec_pc, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dec_stall = 1'b0; exec_redirect = 1'b0; exec_redirect_pc = '0;
    lat = 1; cyc = 0; nxt_pc = 32'h0; first_vld = -1; hs_cnt = 0; hs_seen = 1'b0;
    first_hs_addr = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");

    // 1: streaming from reset, L=1
    rst_n = 1'b1; imem_req_ready = 1'b1;
    repeat (10) tick();
    chk("t1_first_valid_cyc", 32'(first_vld), 32'd3);
    chk("t1_req_count", 32'(hs_cnt), 32'd9);

    // 2: decode stall for 4 cycles
    chk("t2_valid_before", 32'(ftch_dec_valid), 32'd1);
    snap_i = ftch_dec_instr; snap_p = ftch_dec_pc; snap_v = ftch_dec_valid;
    dec_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("t2_req_stopped", 32'(imem_req_valid), 32'd0);
      tick();
      chk("t2_hold_instr", ftch_dec_instr, snap_i);
      chk("t2_hold_pc", ftch_dec_pc, snap_p);
      chk("t2_hold_valid", 32'(ftch_dec_valid), 32'(snap_v));
    end
    dec_stall = 1'b0;
    repeat (8) tick();

    // 3: two outstanding, redirect to 0x100
    lat = 2; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (pend.size() == 2) found = 1'b1;
    end
    chk("t3_two_outstanding", 32'(found), 32'd1);
    exec_redirect = 1'b1; exec_redirect_pc = 32'h100;
    tick();
    exec_redirect = 1'b0; hs_seen = 1'b0;
    wait_first("t3_first_pc", 32'h100);
    chk("t3_first_req", first_hs_addr, 32'h100);

    // 4: redirect coinciding with handshake and response
    lat = 1; repeat (4) tick();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req_valid && imem_req_ready && pend.size() > 0 && pend[0].due == cyc + 1)
        found = 1'b1;
      else
        tick();
    end
    chk("t4_aligned", 32'(found), 32'd1);
    exec_redirect = 1'b1; exec_redirect_pc = 32'h340;
    tick();
    exec_redirect = 1'b0;
    wait_first("t4_first_pc", 32'h340);

    // 5: memory not ready for 3 cycles, misaligned redirect mid-wait
    repeat (4) tick();
    imem_req_ready = 1'b0; snap_a = imem_req_addr;
    chk("t5_valid_w0", 32'(imem_req_valid), 32'd1);
    tick();
    chk("t5_addr_w1", imem_req_addr, snap_a);
    chk("t5_valid_w1", 32'(imem_req_valid), 32'd1);
    exec_redirect = 1'b1; exec_redirect_pc = 32'h203;
    tick();
    exec_redirect = 1'b0;
    chk("t5_addr_redir", imem_req_addr, 32'h200);
    chk("t5_valid_redir", 32'(imem_req_valid), 32'd1);
    tick();
    chk("t5_addr_hold", imem_req_addr, 32'h200);
    imem_req_ready = 1'b1;
    wait_first("t5_first_pc", 32'h200);

    // 6: async reset mid-stream with the buffer full
    repeat (3) tick();
    dec_stall = 1'b1;
    repeat (3) tick();
    chk("t6_full_req_off", 32'(imem_req_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6_rst");
    exp_q.delete(); pend.delete(); imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dec_stall = 1'b0; nxt_pc = 32'h0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; cyc = 0; first_vld = -1; hs_cnt = 0; hs_seen = 1'b0;
    repeat (8) tick();
    chk("t6_first_valid_cyc", 32'(first_vld), 32'd3);
    chk("t6_first_req", first_hs_addr, 32'h0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
